// File: rtl/ahb_bus_mux.sv
// ahb_bus_mux: latches arbiter grants only at AHB handover points and steers the
// address-phase and data-phase owners onto the shared bus. Option: AHB_MUX_DEFAULT_MGR_EN.
module ahb_bus_mux #(
    parameter int MANAGERS = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [MANAGERS-1:0]          m_hbusreq,
    input  logic [MANAGERS*ADDR_W-1:0]   m_haddr,
    input  logic [MANAGERS*2-1:0]        m_htrans,
    input  logic [MANAGERS-1:0]          m_hwrite,
    input  logic [MANAGERS*3-1:0]        m_hsize,
    input  logic [MANAGERS*3-1:0]        m_hburst,
    input  logic [MANAGERS*DATA_W-1:0]   m_hwdata,
    output logic [MANAGERS-1:0]          requestV,
    input  logic [MANAGERS-1:0]          grantedV,
    output logic [MANAGERS-1:0]          m_hgrant,
    output logic [MANAGERS-1:0]          m_hready,
    output logic                         m_hresp,
    output logic [DATA_W-1:0]            m_hrdata,
    output logic [ADDR_W-1:0]            haddr,
    output logic [1:0]                   htrans,
    output logic                         hwrite,
    output logic [2:0]                   hsize,
    output logic [2:0]                   hburst,
    output logic [DATA_W-1:0]            hwdata,
    input  logic                         hready,
    input  logic                         hresp,
    input  logic [DATA_W-1:0]            hrdata,
    output logic [$clog2(MANAGERS)-1:0]  hmaster
);
    localparam int IDX_W = $clog2(MANAGERS);
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] HB_SINGLE = 3'd0;
    localparam logic [2:0] HB_INCR   = 3'd1;
`ifdef AHB_MUX_DEFAULT_MGR_EN
    localparam logic [MANAGERS-1:0] GRANT_PARK = MANAGERS'(1);
`else
    localparam logic [MANAGERS-1:0] GRANT_PARK = '0;
`endif

    logic [MANAGERS-1:0] grant_q, grant_d;
    logic                aown_vld_q, aown_vld_d;
    logic [IDX_W-1:0]    aown_idx_q, aown_idx_d;
    logic                down_vld_q, down_vld_d;
    logic [IDX_W-1:0]    down_idx_q, down_idx_d;
    logic [4:0]          beats_q, beats_d;
    logic                incr_q, incr_d;

    logic [IDX_W-1:0]    gnt_idx;
    logic [ADDR_W-1:0]   own_haddr;
    logic [1:0]          own_htrans;
    logic                own_hwrite;
    logic [2:0]          own_hsize;
    logic [2:0]          own_hburst;
    logic [4:0]          burst_len_m1;
    logic                own_nonseq, own_seq, accepted, boundary;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < MANAGERS; i++) begin
            if (grant_q[i]) gnt_idx = IDX_W'(i);
        end
    end

    // Address/control mux; an invalid owner reads as an idle, all-zero manager.
    always_comb begin
        own_haddr  = '0;
        own_htrans = TR_IDLE;
        own_hwrite = 1'b0;
        own_hsize  = '0;
        own_hburst = '0;
        if (aown_vld_q) begin
            own_haddr  = m_haddr[int'(aown_idx_q)*ADDR_W +: ADDR_W];
            own_htrans = m_htrans[int'(aown_idx_q)*2 +: 2];
            own_hwrite = m_hwrite[aown_idx_q];
            own_hsize  = m_hsize[int'(aown_idx_q)*3 +: 3];
            own_hburst = m_hburst[int'(aown_idx_q)*3 +: 3];
        end
    end

    always_comb begin
        hwdata = '0;
        if (down_vld_q) hwdata = m_hwdata[int'(down_idx_q)*DATA_W +: DATA_W];
    end

    always_comb begin
        case (own_hburst)
            3'd2, 3'd3: burst_len_m1 = 5'd3;
            3'd4, 3'd5: burst_len_m1 = 5'd7;
            3'd6, 3'd7: burst_len_m1 = 5'd15;
            default:    burst_len_m1 = 5'd0;
        endcase
    end

    assign own_nonseq = (own_htrans == TR_NONSEQ);
    assign own_seq    = (own_htrans == TR_SEQ);
    assign accepted   = hready && aown_vld_q;
    // BUSY matches none of these terms; undefined INCR keeps beats_q at 0 so only IDLE or ERROR release it.
    assign boundary   = hready && (!aown_vld_q || (own_htrans == TR_IDLE)
                                   || (own_nonseq && own_hburst == HB_SINGLE)
                                   || (own_seq && beats_q == 5'd1 && !incr_q)
                                   || hresp);

    always_comb begin
        grant_d    = grant_q;
        aown_vld_d = aown_vld_q;
        aown_idx_d = aown_idx_q;
        down_vld_d = down_vld_q;
        down_idx_d = down_idx_q;
        beats_d    = beats_q;
        incr_d     = incr_q;
        if (hready) begin
            if (boundary) grant_d = (grantedV == '0) ? GRANT_PARK : grantedV;
            aown_vld_d = |grant_q;
            aown_idx_d = gnt_idx;
            down_vld_d = aown_vld_q && (own_nonseq || own_seq);
            down_idx_d = aown_idx_q;
        end
        if (accepted && own_nonseq) begin
            beats_d = burst_len_m1;
            incr_d  = (own_hburst == HB_INCR);
        end else if (accepted && own_seq && beats_q != 5'd0) begin
            beats_d = beats_q - 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q    <= GRANT_PARK;
            aown_vld_q <= 1'b0;
            aown_idx_q <= '0;
            down_vld_q <= 1'b0;
            down_idx_q <= '0;
            beats_q    <= '0;
            incr_q     <= 1'b0;
        end else begin
            grant_q    <= grant_d;
            aown_vld_q <= aown_vld_d;
            aown_idx_q <= aown_idx_d;
            down_vld_q <= down_vld_d;
            down_idx_q <= down_idx_d;
            beats_q    <= beats_d;
            incr_q     <= incr_d;
        end
    end

    assign requestV = m_hbusreq;
    assign m_hgrant = grant_q;
    assign m_hready = {MANAGERS{hready}};
    assign m_hresp  = hresp;
    assign m_hrdata = hrdata;
    assign haddr    = own_haddr;
    assign htrans   = own_htrans;
    assign hwrite   = own_hwrite;
    assign hsize    = own_hsize;
    assign hburst   = own_hburst;
    assign hmaster  = aown_idx_q;

endmodule

// File: tb/tb_ahb_bus_mux.sv
// Directed bench for ahb_bus_mux: grant latency, burst handover, stalls, INCR/BUSY, ERROR, async reset.
module tb_ahb_bus_mux;
    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, INCR4 = 3'd3, INCR8 = 3'd5;
`ifdef AHB_MUX_DEFAULT_MGR_EN
    localparam logic [3:0] PARK = 4'b0001;
`else
    localparam logic [3:0] PARK = 4'b0000;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   m_hbusreq;
    logic [127:0] m_haddr;
    logic [7:0]   m_htrans;
    logic [3:0]   m_hwrite;
    logic [11:0]  m_hsize;
    logic [11:0]  m_hburst;
    logic [127:0] m_hwdata;
    logic [3:0]   requestV, grantedV, m_hgrant, m_hready;
    logic         m_hresp;
    logic [31:0]  m_hrdata;
    logic [31:0]  haddr, hwdata, hrdata;
    logic [1:0]   htrans;
    logic         hwrite, hready, hresp;
    logic [2:0]   hsize, hburst;
    logic [1:0]   hmaster;

    logic [1:0]  tr [4];
    logic [2:0]  bu [4];
    logic [31:0] ad [4];
    logic        wr [4];
    logic [31:0] wd [4];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always_comb begin
        m_haddr = '0; m_htrans = '0; m_hwrite = '0; m_hsize = '0; m_hburst = '0; m_hwdata = '0;
        for (int i = 0; i < 4; i++) begin
            m_haddr[i*32 +: 32]  = ad[i];
            m_htrans[i*2 +: 2]   = tr[i];
            m_hwrite[i]          = wr[i];
            m_hsize[i*3 +: 3]    = 3'd2;
            m_hburst[i*3 +: 3]   = bu[i];
            m_hwdata[i*32 +: 32] = wd[i];
        end
    end

    ahb_bus_mux #(.MANAGERS(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_hbusreq(m_hbusreq), .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite),
        .m_hsize(m_hsize), .m_hburst(m_hburst), .m_hwdata(m_hwdata),
        .requestV(requestV), .grantedV(grantedV), .m_hgrant(m_hgrant),
        .m_hready(m_hready), .m_hresp(m_hresp), .m_hrdata(m_hrdata),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hwdata(hwdata), .hready(hready), .hresp(hresp), .hrdata(hrdata), .hmaster(hmaster)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; hready = 1'b1; hresp = 1'b0; hrdata = '0;
        m_hbusreq = '0; grantedV = '0;
        for (int i = 0; i < 4; i++) begin
            tr[i] = IDLE; bu[i] = SINGLE; ad[i] = '0; wr[i] = 1'b0; wd[i] = '0;
        end
        #2;
        chk("rst_hgrant",  64'(m_hgrant), 64'(PARK));
        chk("rst_htrans",  64'(htrans),   64'(IDLE));
        chk("rst_haddr",   64'(haddr),    64'(0));
        chk("rst_hmaster", 64'(hmaster),  64'(0));
        chk("rst_hwdata",  64'(hwdata),   64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // grant latency: request in N, grant in N+1, ownership in N+2
        m_hbusreq = 4'b0010; grantedV = 4'b0010; #1;
        chk("requestV", 64'(requestV), 64'(4'b0010));
        tick();
        chk("lat_grant_n1", 64'(m_hgrant), 64'(4'b0010));
        chk("lat_haddr_n1", 64'(haddr),    64'(0));
        tr[1] = NONSEQ; bu[1] = SINGLE; ad[1] = 32'h0000_1000; wr[1] = 1'b1;
        tick();
        hrdata = 32'hDEAD_BEEF; #1;
        chk("lat_hmaster_n2", 64'(hmaster), 64'(1));
        chk("lat_haddr_n2",   64'(haddr),   64'(32'h0000_1000));
        chk("lat_htrans_n2",  64'(htrans),  64'(NONSEQ));
        chk("lat_hwrite_n2",  64'(hwrite),  64'(1));
        chk("bcast_hrdata",   64'(m_hrdata), 64'(32'hDEAD_BEEF));
        chk("bcast_hready",   64'(m_hready), 64'(4'b1111));
        tick();
        tr[1] = IDLE; wd[1] = 32'hA5A5_0001; m_hbusreq = '0; grantedV = '0; #1;
        chk("single_hwdata", 64'(hwdata), 64'(32'hA5A5_0001));
        chk("single_idle",   64'(htrans), 64'(IDLE));
        tick();
        chk("release_grant", 64'(m_hgrant), 64'(PARK));
        chk("release_hwdata", 64'(hwdata),  64'(0));
        tick();
        chk("release_hmaster", 64'(hmaster), 64'(0));

        // INCR4 on manager 0 while manager 2 waits
        m_hbusreq = 4'b0001; grantedV = 4'b0001;
        tick();
        chk("m0_grant", 64'(m_hgrant), 64'(4'b0001));
        tick();
        tr[0] = NONSEQ; bu[0] = INCR4; ad[0] = 32'h100; wr[0] = 1'b1;
        m_hbusreq = 4'b0101; grantedV = 4'b0100; #1;
        chk("incr4_hmaster", 64'(hmaster), 64'(0));
        chk("incr4_haddr",   64'(haddr),   64'(32'h100));
        chk("incr4_hburst",  64'(hburst),  64'(INCR4));
        for (int b = 1; b <= 3; b++) begin
            tick();
            tr[0] = SEQ; ad[0] = 32'h100 + 32'(4*b); wd[0] = 32'hB000 + 32'(b-1); #1;
            chk("incr4_hold",   64'(m_hgrant), 64'(4'b0001));
            chk("incr4_hwdata", 64'(hwdata),   64'(32'hB000 + 32'(b-1)));
        end
        tick();
        tr[0] = IDLE; wd[0] = 32'hB003; #1;
        chk("handover_grant",   64'(m_hgrant), 64'(4'b0100));
        chk("handover_idle",    64'(htrans),   64'(IDLE));
        chk("handover_hmaster", 64'(hmaster),  64'(0));
        chk("handover_hwdata",  64'(hwdata),   64'(32'hB003));
        tick();
        tr[2] = NONSEQ; bu[2] = INCR4; ad[2] = 32'h2000; wr[2] = 1'b0;
        m_hbusreq = 4'b0001; grantedV = 4'b0001; #1;
        chk("m2_hmaster", 64'(hmaster), 64'(2));
        chk("m2_htrans",  64'(htrans),  64'(NONSEQ));
        chk("m2_haddr",   64'(haddr),   64'(32'h2000));

        // hready low for three cycles in the middle of manager 2's INCR4
        tick();
        tr[2] = SEQ; ad[2] = 32'h2004; #1;
        chk("stall_pre_grant", 64'(m_hgrant), 64'(4'b0100));
        tick();
        ad[2] = 32'h2008; wd[2] = 32'hC0DE_0002; hready = 1'b0; #1;
        for (int k = 0; k < 3; k++) begin
            chk("stall_htrans", 64'(htrans),   64'(SEQ));
            chk("stall_haddr",  64'(haddr),    64'(32'h2008));
            chk("stall_grant",  64'(m_hgrant), 64'(4'b0100));
            chk("stall_hready", 64'(m_hready), 64'(4'b0000));
            chk("stall_hwdata", 64'(hwdata),   64'(32'hC0DE_0002));
            tick();
        end
        hready = 1'b1; #1;
        chk("stall_resume_hmaster", 64'(hmaster), 64'(2));
        chk("stall_resume_haddr",   64'(haddr),   64'(32'h2008));
        tick();
        ad[2] = 32'h200C; #1;
        chk("stall_last_beat_hold", 64'(m_hgrant), 64'(4'b0100));
        tick();
        tr[2] = IDLE; #1;
        chk("stall_handover", 64'(m_hgrant), 64'(4'b0001));
        chk("stall_idle",     64'(htrans),   64'(IDLE));

        // undefined INCR with BUSY cycles on manager 0
        tick();
        tr[0] = NONSEQ; bu[0] = INCR; ad[0] = 32'h300; #1;
        chk("incr_hmaster", 64'(hmaster), 64'(0));
        chk("incr_hburst",  64'(hburst),  64'(INCR));
        for (int k = 0; k < 4; k++) begin
            tick();
            tr[0] = (k % 2 == 0) ? BUSY : SEQ;
            if (k % 2 == 1) ad[0] = ad[0] + 32'd4;
            m_hbusreq = 4'b0101; grantedV = 4'b0100; #1;
            chk("incr_busy_hold", 64'(m_hgrant), 64'(4'b0001));
        end
        tick();
        tr[0] = IDLE; #1;
        chk("incr_hold_last", 64'(m_hgrant), 64'(4'b0001));
        tick();
        chk("incr_release", 64'(m_hgrant), 64'(4'b0100));

        // ERROR on beat 2 of manager 2's INCR8
        tick();
        tr[2] = NONSEQ; bu[2] = INCR8; ad[2] = 32'h400; m_hbusreq = 4'b1100; grantedV = 4'b1000; #1;
        chk("incr8_hmaster", 64'(hmaster), 64'(2));
        tick();
        tr[2] = SEQ; ad[2] = 32'h404; hready = 1'b0; hresp = 1'b1; #1;
        chk("err_hresp",      64'(m_hresp),  64'(1));
        chk("err_wait_grant", 64'(m_hgrant), 64'(4'b0100));
        tick();
        hready = 1'b1; #1;
        chk("err_hold", 64'(m_hgrant), 64'(4'b0100));
        tick();
        hresp = 1'b0; tr[2] = IDLE; #1;
        chk("err_handover", 64'(m_hgrant), 64'(4'b1000));
        chk("err_idle",     64'(htrans),   64'(IDLE));

        // asynchronous reset in the middle of manager 3's INCR4
        tick();
        tr[3] = NONSEQ; bu[3] = INCR4; ad[3] = 32'h500; wr[3] = 1'b1; #1;
        chk("m3_hmaster", 64'(hmaster), 64'(3));
        tick();
        tr[3] = SEQ; ad[3] = 32'h504; wd[3] = 32'hC000; #1;
        chk("m3_hwdata", 64'(hwdata), 64'(32'hC000));
        #1; rst_n = 1'b0; #1;
        chk("arst_hgrant",  64'(m_hgrant), 64'(PARK));
        chk("arst_htrans",  64'(htrans),   64'(IDLE));
        chk("arst_haddr",   64'(haddr),    64'(0));
        chk("arst_hmaster", 64'(hmaster),  64'(0));
        chk("arst_hwdata",  64'(hwdata),   64'(0));
        chk("arst_hwrite",  64'(hwrite),   64'(0));
        @(negedge clk);
        rst_n = 1'b1; m_hbusreq = '0; grantedV = '0;
        for (int i = 0; i < 4; i++) tr[i] = IDLE;
        tick();
        chk("post_rst_grant",  64'(m_hgrant), 64'(PARK));
        chk("post_rst_htrans", 64'(htrans),   64'(IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
